// File: rtl/dmem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_unit_pkg
// Description : Shared encodings and constants for the MEM-stage data-memory
//               access unit (FSM states, abort data, alignment helper).
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_access_unit_pkg;

  // Access FSM states
  typedef enum logic [1:0] {
    DAU_IDLE = 2'd0,
    DAU_REQ  = 2'd1,
    DAU_DONE = 2'd2
  } dau_state_t;

  // Value handed back to the pipeline when a load is aborted
  localparam logic [31:0] c_ERR_DATA_DEFAULT = 32'hDEADBEEF;

  // Width of the bus-wait counter
  localparam int c_CNT_W = 8;

  // Word accesses only: the two low address bits must be zero
  function automatic logic is_aligned(input logic [1:0] i_lsb);
    return (i_lsb == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_timeout_counter
// Description : Counts cycles spent waiting for a bus acknowledge and flags
//               the last permitted cycle so the caller can abort.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_timeout_counter
  import dmem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(TIMEOUT - 1);

  logic [c_CNT_W-1:0] r_count;

  // Cleared on every new access, then advances once per waiting cycle;
  // saturates rather than wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != {c_CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expiry is only meaningful while the caller is actually waiting
  assign o_expire = i_enable && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : dmem_access_unit
// Description : Converts a one-cycle MEM-stage load/store into a req/ack
//               transaction on a slow data bus, stalling the pipeline until
//               completion and reporting misaligned or timed-out accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter int                TIMEOUT  = 64,
  parameter logic [DATA_W-1:0] ERR_DATA = c_ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              DMEM_rena,
  input  logic              DMEM_wena,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ack,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err,
  output logic              misalign_err
);

  dau_state_t        r_state;
  dau_state_t        w_next;
  logic              w_any_req;
  logic              w_aligned;
  logic              w_start;
  logic              w_misalign;
  logic              w_ack_done;
  logic              w_abort;
  logic              w_expire;

  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_bus_err;
  logic              r_misalign;

  assign w_any_req = DMEM_rena | DMEM_wena;
  assign w_aligned = is_aligned(addr[1:0]);

  dmem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_start),
    .i_enable (r_state == DAU_REQ),
    .o_expire (w_expire)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= DAU_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and per-cycle events; ack beats a simultaneous expiry
  always_comb begin
    w_next     = r_state;
    w_start    = 1'b0;
    w_misalign = 1'b0;
    w_ack_done = 1'b0;
    w_abort    = 1'b0;
    case (r_state)
      DAU_IDLE: begin
        if (w_any_req) begin
          if (w_aligned) begin
            w_start = 1'b1;
            w_next  = DAU_REQ;
          end else begin
            w_misalign = 1'b1;
          end
        end
      end
      DAU_REQ: begin
        if (bus_ack) begin
          w_ack_done = 1'b1;
          w_next     = DAU_DONE;
        end else if (w_expire) begin
          w_abort = 1'b1;
          w_next  = DAU_DONE;
        end
      end
      DAU_DONE: w_next = DAU_IDLE;
      default:  w_next = DAU_IDLE;
    endcase
  end

  // Bus register bank, load result and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_rdata     <= '0;
      r_bus_err   <= 1'b0;
      r_misalign  <= 1'b0;
    end else begin
      r_bus_err  <= w_abort;
      r_misalign <= w_misalign;
      if (w_start) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= DMEM_wena;  // write wins if both enables are high
        r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
        r_bus_wdata <= wdata;
      end
      if (w_ack_done || w_abort) begin
        r_bus_req <= 1'b0;
      end
      if (w_ack_done && !r_bus_we) begin
        r_rdata <= bus_rdata;
      end
      if (w_abort && !r_bus_we) begin
        r_rdata <= ERR_DATA;
      end
    end
  end

  // Stall covers the request cycle and every waiting cycle, never DONE
  assign stall = !rst && (((r_state == DAU_IDLE) && w_any_req && w_aligned) ||
                          (r_state == DAU_REQ));

  assign bus_req      = r_bus_req;
  assign bus_we       = r_bus_we;
  assign bus_addr     = r_bus_addr;
  assign bus_wdata    = r_bus_wdata;
  assign rdata        = r_rdata;
  assign bus_err      = r_bus_err;
  assign misalign_err = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_access_unit
// Description : Self-checking bench for dmem_access_unit: directed cases plus
//               randomized accesses against a transaction-level model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        DMEM_rena = 1'b0;
  logic        DMEM_wena = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err;
  logic        misalign_err;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_rdata = '0;

  dmem_access_unit #(
    .DATA_W   (32),
    .ADDR_W   (32),
    .TIMEOUT  (TO),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .DMEM_rena    (DMEM_rena),
    .DMEM_wena    (DMEM_wena),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .stall        (stall),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .bus_err      (bus_err),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One aligned access. d = REQ cycle in which memory acks (0 = never).
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input int d, input logic [31:0] rdat);
    int   stall_cnt;
    int   req_cnt;
    logic done;
    logic acked;
    int   exp_req;
    @(posedge clk); #1;
    DMEM_rena = rd; DMEM_wena = wr; addr = a; wdata = wd; bus_ack = 1'b0;
    #1;
    check("req_cycle_bus_req", bus_req, 0);
    check("prev_bus_err_width", bus_err, 0);
    check("prev_misalign", misalign_err, 0);
    stall_cnt = 0; req_cnt = 0; done = 1'b0;
    for (int cyc = 0; cyc < 50 && !done; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #2; end
      bus_ack = 1'b0;
      if (!stall) begin
        done = 1'b1;
      end else begin
        stall_cnt++;
        if (bus_req) begin
          req_cnt++;
          if (req_cnt == 1) begin
            check("bus_addr", bus_addr, a);
            check("bus_we", bus_we, wr);
            check("bus_wdata", bus_wdata, wd);
          end
          bus_ack   = (req_cnt == d);
          bus_rdata = bus_ack ? rdat : $urandom();
        end
      end
    end
    check("wait_budget", done, 1);
    // Transaction-level expectation
    acked   = (d >= 1) && (d <= TO);
    exp_req = acked ? d : TO;
    if (!wr) exp_rdata = acked ? rdat : 32'hDEADBEEF;
    check("stall_cycles", stall_cnt, exp_req + 1);
    check("bus_req_cycles", req_cnt, exp_req);
    check("done_bus_req", bus_req, 0);
    check("done_bus_err", bus_err, !acked);
    check("done_rdata", rdata, exp_rdata);
  endtask

  task automatic misaligned(input logic rd, input logic wr, input logic [31:0] a);
    @(posedge clk); #1;
    DMEM_rena = rd; DMEM_wena = wr; addr = a; bus_ack = 1'b0;
    #1;
    check("mis_stall", stall, 0);
    check("mis_bus_req", bus_req, 0);
    @(posedge clk); #1;
    DMEM_rena = 1'b0; DMEM_wena = 1'b0;
    #1;
    check("mis_err_pulse", misalign_err, 1);
    check("mis_no_req", bus_req, 0);
    check("mis_rdata", rdata, exp_rdata);
    @(posedge clk); #2;
    check("mis_err_width", misalign_err, 0);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    DMEM_rena = 1'b0; DMEM_wena = 1'b0; bus_ack = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    int          kind;
    // Reset with a request held: stall must stay low
    DMEM_rena = 1'b1; addr = 32'h0;
    @(posedge clk); @(posedge clk); #2;
    check("rst_stall", stall, 0);
    check("rst_bus_req", bus_req, 0);
    check("rst_rdata", rdata, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_bus_err", bus_err, 0);
    check("rst_misalign", misalign_err, 0);
    DMEM_rena = 1'b0; rst = 1'b0;
    idle_cycle();

    // Directed cases
    access(1, 0, 32'h10, 32'h0, 3, 32'h12345678);
    idle_cycle();
    access(0, 1, 32'h20, 32'hCAFEF00D, 1, 32'h0);
    idle_cycle();
    access(1, 0, 32'h30, 32'h0, 0, 32'h0);           // no ack -> abort
    idle_cycle();
    misaligned(1, 0, 32'h13);
    access(1, 0, 32'h40, 32'h0, 2, 32'hA5A50040);    // back-to-back loads
    access(1, 0, 32'h44, 32'h0, 1, 32'h5A5A0044);
    idle_cycle();
    access(1, 0, 32'h50, 32'h0, TO, 32'h0BADF00D);   // ack on last cycle wins
    idle_cycle();
    access(1, 1, 32'h60, 32'h11112222, 2, 32'h99999999); // both -> store
    idle_cycle();

    // Randomized accesses
    for (int i = 0; i < 24; i++) begin
      r    = $urandom();
      kind = $urandom_range(0, 3);
      case (kind)
        0: access(1, 0, r & ~32'h3, $urandom(), $urandom_range(0, 6), $urandom());
        1: access(0, 1, r & ~32'h3, $urandom(), $urandom_range(0, 6), $urandom());
        2: access(1, 1, r & ~32'h3, $urandom(), $urandom_range(0, 6), $urandom());
        default: misaligned(1'($urandom_range(0, 1)), 1'b1, (r & ~32'h3) | 32'($urandom_range(1, 3)));
      endcase
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end

    // Reset in the second REQ cycle, then a stray ack
    idle_cycle();
    @(posedge clk); #1;
    DMEM_rena = 1'b1; addr = 32'h80;
    @(posedge clk); #1;                 // REQ cycle 1
    @(posedge clk); #1;                 // REQ cycle 2
    check("pre_rst_bus_req", bus_req, 1);
    rst = 1'b1;
    #1;
    check("rst_forces_stall_low", stall, 0);
    @(posedge clk); #1;
    rst = 1'b0; DMEM_rena = 1'b0;
    #1;
    check("post_rst_bus_req", bus_req, 0);
    check("post_rst_stall", stall, 0);
    bus_ack = 1'b1; bus_rdata = 32'h77777777;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    #1;
    exp_rdata = 32'h0;
    check("stray_ack_bus_req", bus_req, 0);
    check("stray_ack_rdata", rdata, exp_rdata);
    check("stray_ack_bus_err", bus_err, 0);
    check("stray_ack_bus_we", bus_we, 0);
    check("stray_ack_bus_addr", bus_addr, 0);
    check("stray_ack_bus_wdata", bus_wdata, 0);
    check("stray_ack_misalign", misalign_err, 0);
    check("stray_ack_stall", stall, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
